mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arb_pkg.sv | 20 ++
 rtl/sat_counter.sv | 23 ++
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
package arb_pkg;

    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_CNT_W  = 16;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // A data response must know whether it returns load data or a store ack.
    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_LOAD  = 2'd1,
        D_STORE = 2'd2
    } d_pend_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous increment and asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch port and a data port.
// Handshake: a port holds req/addr (and we/wdata) until gnt is high in the same cycle; valid follows gnt by exactly one cycle.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt,
    output owner_t            o_dbg_last_owner
);

    owner_t  r_last_owner;
    owner_t  w_owner_next;
    d_pend_t r_d_pend;
    d_pend_t w_d_pend_next;
    logic    r_if_pend;
    logic    w_if_gnt;
    logic    w_d_gnt;
    logic    w_conflict;
    logic    w_unused_addr_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OWN_D;
            r_if_pend    <= 1'b0;
            r_d_pend     <= D_IDLE;
        end else begin
            r_last_owner <= w_owner_next;
            r_if_pend    <= w_if_gnt;
            r_d_pend     <= w_d_pend_next;
        end
    end

    // Grants are suppressed while reset is held so nothing reaches memory.
    always_comb begin
        w_if_gnt      = 1'b0;
        w_d_gnt       = 1'b0;
        w_owner_next  = r_last_owner;
        w_d_pend_next = D_IDLE;
        if (rst_n) begin
            if (if_req && (!d_req || (r_last_owner == OWN_D))) begin
                w_if_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
        if (w_if_gnt) begin
            w_owner_next = OWN_IF;
        end else if (w_d_gnt) begin
            w_owner_next  = OWN_D;
            w_d_pend_next = d_we ? D_STORE : D_LOAD;
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign mem_en    = w_if_gnt | w_d_gnt;
    assign mem_we    = w_d_gnt & d_we;
    assign mem_addr  = w_d_gnt  ? d_addr[ADDR_W-1:2] :
                       w_if_gnt ? if_addr[ADDR_W-1:2] : '0;
    assign mem_wdata = mem_en ? d_wdata : '0;

    assign w_unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    assign if_valid = r_if_pend;
    assign if_rdata = r_if_pend ? mem_rdata : '0;
    assign d_valid  = (r_d_pend != D_IDLE);
    assign d_rdata  = (r_d_pend == D_LOAD) ? mem_rdata : '0;

    assign o_dbg_last_owner = r_last_owner;

    assign w_conflict = if_req & d_req;

    sat_counter #(
        .W (ARB_CNT_W)
    ) u_conflict_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_conflict),
        .o_count (conflict_cnt)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reference model plus per-port expected-data queues.
module tb_mem_arbiter;
    import arb_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int WORDS  = 64;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              if_req, if_gnt, if_valid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_we, d_gnt, d_valid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [15:0]       conflict_cnt;
    owner_t            dbg_owner;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_gnt           (if_gnt),
        .if_valid         (if_valid),
        .if_rdata         (if_rdata),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_gnt            (d_gnt),
        .d_valid          (d_valid),
        .d_rdata          (d_rdata),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .conflict_cnt     (conflict_cnt),
        .o_dbg_last_owner (dbg_owner)
    );

    function automatic logic [DATA_W-1:0] init_word(int i);
        return {16'hA5C3, 8'(i), 8'(i * 3)};
    endfunction

    // memory behind the arbiter: one-cycle read latency, contents restored on reset
    logic [DATA_W-1:0] mem [WORDS];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // scoreboard / reference model
    logic [DATA_W-1:0] exp_if_q[$];
    logic [DATA_W-1:0] exp_d_q[$];
    logic [DATA_W-1:0] shadow [WORDS];
    owner_t            m_owner;
    logic              m_if_pend, m_d_pend;
    logic [15:0]       m_cnt;
    int                n_checks = 0;
    int                n_pass   = 0;

    logic              obs_if_gnt, obs_d_gnt, obs_if_valid, obs_d_valid, obs_mem_we;
    logic [DATA_W-1:0] obs_if_rdata, obs_d_rdata;
    logic [ADDR_W-3:0] obs_mem_addr;
    logic [15:0]       obs_cnt;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner   = OWN_D;
        m_if_pend = 1'b0;
        m_d_pend  = 1'b0;
        m_cnt     = '0;
        exp_if_q.delete();
        exp_d_q.delete();
        for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
    endtask

    // driver: one clock cycle of requests, checked mid-cycle against the model
    task automatic step(input logic ir, input logic [7:0] ia, input logic dr,
                        input logic dw, input logic [7:0] da, input logic [31:0] dd);
        logic              e_if, e_d;
        logic [ADDR_W-3:0] e_addr;
        logic [DATA_W-1:0] e_data;
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        @(negedge clk);
        e_if   = ir && (!dr || (m_owner == OWN_D));
        e_d    = dr && !e_if;
        e_addr = e_if ? ia[7:2] : (e_d ? da[7:2] : '0);
        obs_if_gnt = if_gnt; obs_d_gnt = d_gnt; obs_mem_we = mem_we; obs_mem_addr = mem_addr;
        obs_if_valid = if_valid; obs_d_valid = d_valid; obs_if_rdata = if_rdata;
        obs_d_rdata = d_rdata; obs_cnt = conflict_cnt;
        check_val("if_gnt", 32'(if_gnt), 32'(e_if));
        check_val("d_gnt", 32'(d_gnt), 32'(e_d));
        check_val("mem_en", 32'(mem_en), 32'(e_if | e_d));
        check_val("mem_we", 32'(mem_we), 32'(e_d & dw));
        check_val("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_d && dw) check_val("mem_wdata", mem_wdata, dd);
        if (!(e_if || e_d)) check_val("mem_wdata_idle", mem_wdata, 32'h0);
        check_val("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        check_val("last_owner", 32'(dbg_owner), 32'(m_owner));
        check_val("if_valid", 32'(if_valid), 32'(m_if_pend));
        check_val("d_valid", 32'(d_valid), 32'(m_d_pend));
        if (m_if_pend && exp_if_q.size() > 0) check_val("if_rdata", if_rdata, exp_if_q.pop_front());
        else if (!m_if_pend) check_val("if_rdata_idle", if_rdata, 32'h0);
        if (m_d_pend && exp_d_q.size() > 0) check_val("d_rdata", d_rdata, exp_d_q.pop_front());
        else if (!m_d_pend) check_val("d_rdata_idle", d_rdata, 32'h0);
        if (e_if) exp_if_q.push_back(shadow[ia[7:2]]);
        if (e_d) begin
            if (dw) begin
                e_data = '0;
                shadow[da[7:2]] = dd;
            end else begin
                e_data = shadow[da[7:2]];
            end
            exp_d_q.push_back(e_data);
        end
        m_if_pend = e_if;
        m_d_pend  = e_d;
        if (e_if) m_owner = OWN_IF;
        else if (e_d) m_owner = OWN_D;
        if (ir && dr && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    // reset held across one rising edge with both requests raised
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; if_addr = 8'h14; d_addr = 8'h18; d_wdata = 32'h1234_5678;
        @(negedge clk);
        check_val("rst_if_gnt", 32'(if_gnt), 32'h0);
        check_val("rst_d_gnt", 32'(d_gnt), 32'h0);
        check_val("rst_if_valid", 32'(if_valid), 32'h0);
        check_val("rst_d_valid", 32'(d_valid), 32'h0);
        check_val("rst_if_rdata", if_rdata, 32'h0);
        check_val("rst_d_rdata", d_rdata, 32'h0);
        check_val("rst_mem_en", 32'(mem_en), 32'h0);
        check_val("rst_mem_we", 32'(mem_we), 32'h0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_val("rst_mem_wdata", mem_wdata, 32'h0);
        check_val("rst_conflict_cnt", 32'(conflict_cnt), 32'h0);
        check_val("rst_last_owner", 32'(dbg_owner), 32'(OWN_D));
        @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        model_reset();
        do_reset();

        // fetch-only stream at word 2, low address bits ignored
        step(1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 32'h0);
        check_val("f1_gnt", 32'(obs_if_gnt), 32'h1);
        check_val("f1_addr", 32'(obs_mem_addr), 32'h2);
        step(1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 32'h0);
        check_val("f2_valid", 32'(obs_if_valid), 32'h1);
        check_val("f2_rdata", obs_if_rdata, init_word(2));
        step(1'b1, 8'h0B, 1'b0, 1'b0, 8'h00, 32'h0);
        check_val("f3_addr", 32'(obs_mem_addr), 32'h2);
        idle();
        check_val("f4_valid", 32'(obs_if_valid), 32'h1);
        check_val("f4_rdata", obs_if_rdata, init_word(2));
        idle();
        check_val("f5_valid", 32'(obs_if_valid), 32'h0);

        // alternating grants under constant contention
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(4 * i), 1'b1, 1'b0, 8'(4 * i + 32), 32'h0);
            check_val("rr_if_gnt", 32'(obs_if_gnt), 32'((i % 2) == 0));
            check_val("rr_d_gnt", 32'(obs_d_gnt), 32'((i % 2) == 1));
        end
        idle();
        check_val("rr_cnt4", 32'(obs_cnt), 32'd4);

        // store then load at word 3
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h0C, 32'hDEADBEEF);
        check_val("st_we", 32'(obs_mem_we), 32'h1);
        check_val("st_addr", 32'(obs_mem_addr), 32'h3);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h0E, 32'h0);
        check_val("st_ack_valid", 32'(obs_d_valid), 32'h1);
        check_val("st_ack_rdata", obs_d_rdata, 32'h0);
        idle();
        check_val("ld_valid", 32'(obs_d_valid), 32'h1);
        check_val("ld_rdata", obs_d_rdata, 32'hDEADBEEF);

        // random mixed traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), $urandom);
        end
        idle();

        // drive the conflict counter into saturation
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
        end
        idle();
        check_val("cnt_saturated", 32'(obs_cnt), 32'hFFFF);
        idle();
        check_val("cnt_hold", 32'(obs_cnt), 32'hFFFF);

        // reset right after a data grant drops the response
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 32'h0);
        check_val("pre_rst_d_gnt", 32'(obs_d_gnt), 32'h1);
        do_reset();
        idle();
        check_val("post_rst_d_valid", 32'(obs_d_valid), 32'h0);
        step(1'b1, 8'h20, 1'b1, 1'b0, 8'h24, 32'h0);
        check_val("post_rst_if_wins", 32'(obs_if_gnt), 32'h1);
        check_val("post_rst_d_denied", 32'(obs_d_gnt), 32'h0);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
